// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared forwarding-select and hazard-FSM encodings
// Rev 1.0
// ============================================================================
package pipe_pkg;

   localparam logic [1:0] FWD_EXMEM = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_RF    = 2'b10;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } hz_state_t;

   function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/src_match.sv
`default_nettype none
// ============================================================================
// src_match : compares one ID source operand against EX/MEM/WB destinations
// Rev 1.0
// ============================================================================
module src_match #(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_src,
   input  logic              i_used,
   input  logic [REG_AW-1:0] i_ex_wa,
   input  logic              i_ex_we,
   input  logic [REG_AW-1:0] i_mem_wa,
   input  logic              i_mem_we,
   input  logic [REG_AW-1:0] i_wb_wa,
   input  logic              i_wb_we,
   output logic              o_ex_hit,
   output logic              o_mem_hit,
   output logic              o_wb_hit
);

   logic w_live;

   // Register 0 is hardwired, so it can never carry a hazard or a bypass.
   assign w_live    = i_used && (|i_src);
   assign o_ex_hit  = w_live && i_ex_we  && (i_ex_wa  == i_src);
   assign o_mem_hit = w_live && i_mem_we && (i_mem_wa == i_src);
   assign o_wb_hit  = w_live && i_wb_we  && (i_wb_wa  == i_src);

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// fwd_hazard_unit : operand forwarding select, WB->ID bypass and stall control
// Rev 1.0
// ============================================================================
module fwd_hazard_unit
   import pipe_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int CNT_W   = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_src,
   input  logic [NUM_SRC-1:0]        id_src_used,
   input  logic                      id_branch,
   input  logic [REG_AW-1:0]         ex_wa,
   input  logic [REG_AW-1:0]         mem_wa,
   input  logic [REG_AW-1:0]         wb_wa,
   input  logic                      ex_we,
   input  logic                      mem_we,
   input  logic                      wb_we,
   input  logic                      ex_load,
   input  logic                      mem_load,
   output logic [2*NUM_SRC-1:0]      fwd_sel,
   output logic [NUM_SRC-1:0]        id_bypass,
   output logic                      stall,
   output logic                      flush_ex,
   output logic [CNT_W-1:0]          stall_count
);

   logic [NUM_SRC-1:0]   w_ex_hit;
   logic [NUM_SRC-1:0]   w_mem_hit;
   logic [NUM_SRC-1:0]   w_wb_hit;
   logic [1:0]           w_req;
   logic                 w_stall;
   hz_state_t            r_state;
   logic [1:0]           r_rem;
   logic [2*NUM_SRC-1:0] r_fwd_sel;
   logic [CNT_W-1:0]     r_stall_count;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         src_match #(.REG_AW(REG_AW)) u_match (
            .i_src     (id_src[gi*REG_AW +: REG_AW]),
            .i_used    (id_src_used[gi]),
            .i_ex_wa   (ex_wa),
            .i_ex_we   (ex_we),
            .i_mem_wa  (mem_wa),
            .i_mem_we  (mem_we),
            .i_wb_wa   (wb_wa),
            .i_wb_we   (wb_we),
            .o_ex_hit  (w_ex_hit[gi]),
            .o_mem_hit (w_mem_hit[gi]),
            .o_wb_hit  (w_wb_hit[gi])
         );
      end
   endgenerate

   // Worst-case stall demand across every operand and hazard rule.
   always_comb begin
      w_req = 2'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_ex_hit[i] && ex_load && id_valid)
            w_req = max2(w_req, 2'd1);
         if (w_ex_hit[i] && id_branch)
            w_req = max2(w_req, ex_load ? 2'd2 : 2'd1);
         if (w_mem_hit[i] && id_branch && mem_load)
            w_req = max2(w_req, 2'd1);
      end
   end

   assign w_stall   = (r_state == ST_HOLD) || (w_req != 2'd0);
   assign stall     = w_stall && !reset;
   assign flush_ex  = stall;
   assign id_bypass = w_wb_hit;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_rem   <= 2'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_req == 2'd2) begin
                  r_state <= ST_HOLD;
                  r_rem   <= 2'd1;
               end
            end
            ST_HOLD: begin
               if (r_rem <= 2'd1) begin
                  r_state <= ST_RUN;
                  r_rem   <= 2'd0;
               end else begin
                  r_rem   <= r_rem - 2'd1;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_rem   <= 2'd0;
            end
         endcase
      end
   end

   // A bubble or an invalid ID slot reads nothing, so it forwards from the register file.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_fwd_sel <= {NUM_SRC{FWD_RF}};
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (w_stall || !id_valid)
               r_fwd_sel[2*i +: 2] <= FWD_RF;
            else if (w_ex_hit[i])
               r_fwd_sel[2*i +: 2] <= FWD_EXMEM;
            else if (w_mem_hit[i])
               r_fwd_sel[2*i +: 2] <= FWD_MEMWB;
            else
               r_fwd_sel[2*i +: 2] <= FWD_RF;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_stall_count <= '0;
      else if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
         r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign fwd_sel     = r_fwd_sel;
   assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_fwd_hazard_unit : directed vectors plus a cycle-by-cycle behavioural model
// Rev 1.0
// ============================================================================
module tb_fwd_hazard_unit;

   localparam int AW = 5;
   localparam int NS = 2;
   localparam int CW = 4;

   logic            clk;
   logic            rst;
   logic            id_valid;
   logic [NS*AW-1:0] id_src;
   logic [NS-1:0]   id_src_used;
   logic            id_branch;
   logic [AW-1:0]   ex_wa, mem_wa, wb_wa;
   logic            ex_we, mem_we, wb_we;
   logic            ex_load, mem_load;
   logic [2*NS-1:0] fwd_sel;
   logic [NS-1:0]   id_bypass;
   logic            stall;
   logic            flush_ex;
   logic [CW-1:0]   stall_count;

   int n_chk;
   int n_fail;

   // Model state: extra stall cycles still owed, stall count, captured selects.
   int m_owe;
   int m_cnt;
   int m_fwd [NS];

   fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW)) dut (
      .clock       (clk),
      .reset       (rst),
      .id_valid    (id_valid),
      .id_src      (id_src),
      .id_src_used (id_src_used),
      .id_branch   (id_branch),
      .ex_wa       (ex_wa),
      .mem_wa      (mem_wa),
      .wb_wa       (wb_wa),
      .ex_we       (ex_we),
      .mem_we      (mem_we),
      .wb_we       (wb_we),
      .ex_load     (ex_load),
      .mem_load    (mem_load),
      .fwd_sel     (fwd_sel),
      .id_bypass   (id_bypass),
      .stall       (stall),
      .flush_ex    (flush_ex),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit hit(input int i, input int stg);
      logic [AW-1:0] s;
      logic [AW-1:0] wa;
      bit            we;
      s = id_src[i*AW +: AW];
      case (stg)
         0:       begin wa = ex_wa;  we = ex_we;  end
         1:       begin wa = mem_wa; we = mem_we; end
         default: begin wa = wb_wa;  we = wb_we;  end
      endcase
      return id_src_used[i] && we && (wa == s) && (s != 0);
   endfunction

   function automatic int model_req();
      int r = 0;
      for (int i = 0; i < NS; i++) begin
         bit e;
         bit m;
         e = hit(i, 0);
         m = hit(i, 1);
         if (e && ex_load && id_valid && r < 1) r = 1;
         if (e && id_branch) begin
            if (ex_load) r = 2;
            else if (r < 1) r = 1;
         end
         if (m && id_branch && mem_load && r < 1) r = 1;
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owe = 0;
         m_cnt = 0;
         for (int i = 0; i < NS; i++) m_fwd[i] = 2;
      end else begin
         int r;
         bit st;
         r  = model_req();
         st = (m_owe > 0) || (r > 0);
         for (int i = 0; i < NS; i++)
            m_fwd[i] = (st || !id_valid) ? 2 : hit(i, 0) ? 0 : hit(i, 1) ? 1 : 2;
         if (st && m_cnt < (1 << CW) - 1) m_cnt++;
         if (m_owe > 0) m_owe--;
         else if (r == 2) m_owe = 1;
      end
   end

   always @(negedge clk) begin
      logic            e_st;
      logic [2*NS-1:0] e_fwd;
      logic [NS-1:0]   e_byp;
      #2;
      e_st = !rst && ((m_owe > 0) || (model_req() > 0));
      for (int i = 0; i < NS; i++) begin
         e_fwd[2*i +: 2] = 2'(m_fwd[i]);
         e_byp[i]        = hit(i, 2);
      end
      check("cyc_stall", stall, e_st);
      check("cyc_flush", flush_ex, e_st);
      check("cyc_fwd", fwd_sel, e_fwd);
      check("cyc_bypass", id_bypass, e_byp);
      check("cyc_count", stall_count, m_cnt);
   end

   task automatic quiet();
      id_valid = 0; id_src = '0; id_src_used = '0; id_branch = 0;
      ex_wa = '0; mem_wa = '0; wb_wa = '0;
      ex_we = 0; mem_we = 0; wb_we = 0; ex_load = 0; mem_load = 0;
   endtask

   task automatic set_src(input int i, input logic [AW-1:0] v);
      id_src[i*AW +: AW] = v;
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1; quiet();
      id_valid = 1; set_src(0, 3); id_src_used = 2'b01; ex_load = 1; ex_wa = 3; ex_we = 1;
      @(negedge clk); #2;
      check("rst_stall", stall, 0);
      check("rst_flush", flush_ex, 0);
      check("rst_fwd", fwd_sel, 4'b1010);
      check("rst_cnt", stall_count, 0);

      // Register 0 never matches
      @(negedge clk); rst = 0; quiet();
      id_valid = 1; set_src(0, 0); id_src_used = 2'b01; ex_wa = 0; ex_we = 1; wb_wa = 0; wb_we = 1; #2;
      check("r0_stall", stall, 0);
      check("r0_bypass", id_bypass[0], 0);
      @(negedge clk); #2;
      check("r0_fwd", fwd_sel[1:0], 2'b10);

      // EX over MEM priority, then MEM alone
      @(negedge clk); quiet();
      id_valid = 1; set_src(0, 4); id_src_used = 2'b01; ex_wa = 4; ex_we = 1; mem_wa = 4; mem_we = 1;
      @(negedge clk); #2;
      check("exmem_pri", fwd_sel[1:0], 2'b00);
      @(negedge clk); ex_we = 0;
      @(negedge clk); #2;
      check("mem_only", fwd_sel[1:0], 2'b01);

      // Independent operands, WB bypass
      @(negedge clk); quiet();
      id_valid = 1; set_src(0, 4); set_src(1, 6); id_src_used = 2'b11;
      ex_wa = 4; ex_we = 1; mem_wa = 6; mem_we = 1; wb_wa = 9; wb_we = 1; #2;
      check("byp_none", id_bypass, 2'b00);
      @(negedge clk); set_src(1, 9); #2;
      check("byp_op1", id_bypass, 2'b10);
      check("indep_fwd", fwd_sel, 4'b0100);

      // Load-use: one stall cycle
      @(negedge clk); quiet();
      id_valid = 1; set_src(0, 3); id_src_used = 2'b01; ex_load = 1; ex_wa = 3; ex_we = 1; #2;
      check("lu_stall", stall, 1);
      check("lu_flush", flush_ex, 1);
      @(negedge clk); quiet();
      id_valid = 1; set_src(0, 3); id_src_used = 2'b01; mem_wa = 3; mem_we = 1; mem_load = 1; #2;
      check("lu_release", stall, 0);
      check("lu_fwd", fwd_sel[1:0], 2'b10);
      check("lu_cnt", stall_count, 1);
      @(negedge clk); #2;
      check("lu_fwd_mem", fwd_sel[1:0], 2'b01);

      // Branch on EX load: two stall cycles, HOLD ignores inputs
      @(negedge clk); quiet();
      id_valid = 1; id_branch = 1; set_src(1, 7); id_src_used = 2'b10; ex_load = 1; ex_wa = 7; ex_we = 1; #2;
      check("bl_stall1", stall, 1);
      @(negedge clk); quiet(); #2;
      check("bl_stall2", stall, 1);
      @(negedge clk); #2;
      check("bl_done", stall, 0);
      check("bl_cnt", stall_count, 3);

      // Branch on EX non-load, then on MEM load
      @(negedge clk); quiet();
      id_valid = 1; id_branch = 1; set_src(0, 5); id_src_used = 2'b01; ex_wa = 5; ex_we = 1; #2;
      check("be_stall", stall, 1);
      @(negedge clk); quiet();
      id_valid = 1; id_branch = 1; set_src(0, 5); id_src_used = 2'b01; mem_wa = 5; mem_we = 1; mem_load = 1; #2;
      check("bm_stall", stall, 1);
      @(negedge clk); quiet(); #2;
      check("b_done", stall, 0);
      check("b_cnt", stall_count, 5);

      // Non-hazards: branch on MEM non-load, invalid ID, unused operand
      @(negedge clk); quiet();
      id_valid = 1; id_branch = 1; set_src(0, 5); id_src_used = 2'b01; mem_wa = 5; mem_we = 1; #2;
      check("bmnl_stall", stall, 0);
      @(negedge clk); quiet();
      id_valid = 0; set_src(0, 3); id_src_used = 2'b01; ex_load = 1; ex_wa = 3; ex_we = 1; #2;
      check("inv_stall", stall, 0);
      @(negedge clk); id_valid = 1; id_src_used = 2'b00; #2;
      check("unused_stall", stall, 0);
      check("inv_fwd", fwd_sel, 4'b1010);

      // Reset in the first HOLD cycle
      @(negedge clk); quiet();
      id_valid = 1; id_branch = 1; set_src(1, 7); id_src_used = 2'b10; ex_load = 1; ex_wa = 7; ex_we = 1; #2;
      check("rh_pre", stall, 1);
      @(negedge clk); rst = 1; #2;
      check("rh_stall", stall, 0);
      check("rh_cnt", stall_count, 0);
      @(negedge clk); rst = 0; quiet(); #2;
      check("rh_after1", stall, 0);
      @(negedge clk); #2;
      check("rh_after2", stall, 0);
      check("rh_cnt2", stall_count, 0);

      // Saturating counter
      @(negedge clk); quiet();
      id_valid = 1; set_src(0, 3); id_src_used = 2'b01; ex_load = 1; ex_wa = 3; ex_we = 1;
      repeat (20) @(negedge clk);
      #2;
      check("sat_stall", stall, 1);
      check("sat_cnt", stall_count, 15);
      @(negedge clk); quiet();
      repeat (2) @(negedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
